prefetch_receiver: RTL and testbench
====================================

PREFETCH_RECEIVER -- requirements
Module: prefetch_receiver

Interface
REQ-001 Parameters SHALL be: WIDTH, 64, address width; LOGLINE, 6, log2 line bytes; NENTRY, 8, in-flight table entries (power of 2, >=2).
REQ-002 clk  input  1  single clock, all state rising-edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 pf_address_i  input  WIDTH  prefetch byte address from upper-level prefetcher.
REQ-005 pf_valid_i  input  1  prefetch request valid.
REQ-006 pf_ready_o  output  1  request may be accepted this cycle.
REQ-007 mem_req_addr_o  output  WIDTH  line-aligned address to memory.
REQ-008 mem_req_valid_o  output  1  memory request valid.
REQ-009 mem_req_ready_i  input  1  memory accepts request.
REQ-010 mem_resp_valid_i  input  1  memory fill returned.
REQ-011 mem_resp_addr_i  input  WIDTH  fill byte address.
REQ-012 fill_address_o  output  WIDTH  line-aligned filled address to upper level.
REQ-013 fill_prefetch_o  output  1  fill originated from prefetch (always 1 when fill_valid_o).
REQ-014 fill_valid_o  output  1  one-cycle fill pulse.
REQ-015 drop_count_o  output  16  duplicate-drop counter.

Function
REQ-016 Each table entry SHALL hold a line address (addr >> LOGLINE) and a state FREE, PENDING or ISSUED.
REQ-017 pf_ready_o SHALL be combinational from registered state: 1 iff at least one entry is FREE.
REQ-018 Accept occurs on pf_valid_i & pf_ready_o; the line address SHALL be compared to every non-FREE entry as of cycle start.
REQ-019 On match: no allocation, drop_count_o increments by 1, saturating at 16'hFFFF.
REQ-020 On no match: lowest-index FREE entry becomes PENDING with that line address at the next edge.
REQ-021 When mem_req_valid_o is 0 and any entry is PENDING, the lowest-index PENDING entry SHALL be presented next cycle: mem_req_valid_o=1, mem_req_addr_o=line<<LOGLINE.
REQ-022 mem_req_valid_o and mem_req_addr_o SHALL hold stable until mem_req_ready_i; on handshake the entry becomes ISSUED and mem_req_valid_o drops next cycle unless another PENDING entry is loaded in the same edge (back-to-back allowed).
REQ-023 Minimum latency: request accepted at edge t appears on mem_req_valid_o after edge t+1.
REQ-024 mem_resp_valid_i whose line matches an ISSUED entry SHALL free that entry and drive fill_valid_o=1, fill_prefetch_o=1, fill_address_o=line<<LOGLINE for exactly one cycle after the next edge.
REQ-025 Response matching no ISSUED entry (FREE or PENDING) SHALL be ignored: no fill, no state change.
REQ-026 Accept and response-free in the same cycle: freed entry is reusable only from the following cycle; an incoming duplicate of the freed line SHALL be dropped (cycle-start comparison).
REQ-027 Duplicate lines never coexist in the table.
REQ-028 fill_address_o and mem_req_addr_o SHALL be 0 whenever their valid is 0.

Reset
REQ-029 On rst low, asynchronously: all entries FREE, mem_req_valid_o=0, mem_req_addr_o=0, fill_valid_o=0, fill_prefetch_o=0, fill_address_o=0, drop_count_o=0; pf_ready_o then reads 1.
REQ-030 Reset mid-handshake SHALL discard all in-flight entries; later responses for them are ignored per REQ-025.

Structure
REQ-031 Package prefetch_pkg SHALL hold the entry-state enum (FREE, PENDING, ISSUED) and the LOGLINE default.
REQ-032 A sub-module prio_enc (parameterised lowest-set-bit priority encoder with found flag) SHALL be used for both FREE allocation and PENDING issue selection.

Verification
REQ-033 Single request 0x1040, mem_req_ready_i=1 -> mem_req_addr_o=0x1040 valid after edge t+1; response 0x1044 -> fill_address_o=0x1040, fill_valid_o one cycle.
REQ-034 Requests 0x2000 then 0x2010 (same line) -> one memory request, drop_count_o=1.
REQ-035 Nine distinct lines, mem_req_ready_i=0 -> pf_ready_o=0 after eight accepts; one response frees slot -> pf_ready_o=1 next cycle.
REQ-036 mem_req_ready_i held 0 for 5 cycles -> mem_req_addr_o unchanged throughout; entry PENDING until handshake.
REQ-037 Response for 0x9000 never requested -> no fill_valid_o, table unchanged.
REQ-038 rst asserted with 3 ISSUED entries -> all outputs 0 immediately; subsequent responses produce no fill.

Source files
------------

// File: rtl/prefetch_pkg.sv
// Shared types for the prefetch receiver.
// Entry states and the default line size.
package prefetch_pkg;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        PENDING = 2'd1,
        ISSUED  = 2'd2
    } entry_state_e;

    localparam int LOGLINE_DEF = 6;

endpackage

// File: rtl/prio_enc.sv
// Lowest-set-bit priority encoder.
// found is low and idx is zero when no bit is set.
module prio_enc #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prefetch_receiver.sv
// Prefetch in-flight table: dedups lines, issues them to memory
// one at a time and reports matching fills back upstream.
module prefetch_receiver
    import prefetch_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int LOGLINE = LOGLINE_DEF,
    parameter int NENTRY  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pf_address_i,
    input  logic             pf_valid_i,
    output logic             pf_ready_o,
    output logic [WIDTH-1:0] mem_req_addr_o,
    output logic             mem_req_valid_o,
    input  logic             mem_req_ready_i,
    input  logic             mem_resp_valid_i,
    input  logic [WIDTH-1:0] mem_resp_addr_i,
    output logic [WIDTH-1:0] fill_address_o,
    output logic             fill_prefetch_o,
    output logic             fill_valid_o,
    output logic [15:0]      drop_count_o
);

    localparam int LW = WIDTH - LOGLINE;
    localparam int IW = $clog2(NENTRY);

    entry_state_e  state_q [NENTRY];
    logic [LW-1:0] line_q  [NENTRY];
    logic [IW-1:0] req_idx_q;

    logic [LW-1:0]     pf_line;
    logic [LW-1:0]     resp_line;
    logic [NENTRY-1:0] free_vec;
    logic [NENTRY-1:0] pend_vec;
    logic [NENTRY-1:0] dup_vec;
    logic [NENTRY-1:0] resp_vec;
    logic [IW-1:0]     alloc_idx;
    logic [IW-1:0]     issue_idx;
    logic              alloc_found;
    logic              issue_found;
    logic              accept;
    logic              dup;
    logic              hs;
    logic              load;
    logic              resp_hit;

    assign pf_line   = pf_address_i[WIDTH-1:LOGLINE];
    assign resp_line = mem_resp_addr_i[WIDTH-1:LOGLINE];

    // The entry already on the memory port is skipped when picking the next one.
    always_comb begin
        free_vec = '0;
        pend_vec = '0;
        dup_vec  = '0;
        resp_vec = '0;
        for (int i = 0; i < NENTRY; i++) begin
            free_vec[i] = (state_q[i] == FREE);
            pend_vec[i] = (state_q[i] == PENDING) &&
                          !(mem_req_valid_o && req_idx_q == IW'(i));
            dup_vec[i]  = (state_q[i] != FREE) && (line_q[i] == pf_line);
            resp_vec[i] = mem_resp_valid_i && (state_q[i] == ISSUED) &&
                          (line_q[i] == resp_line);
        end
    end

    prio_enc #(.N(NENTRY), .W(IW)) u_alloc (
        .req   (free_vec),
        .idx   (alloc_idx),
        .found (alloc_found)
    );

    prio_enc #(.N(NENTRY), .W(IW)) u_issue (
        .req   (pend_vec),
        .idx   (issue_idx),
        .found (issue_found)
    );

    assign pf_ready_o = alloc_found;
    assign accept     = pf_valid_i && pf_ready_o;
    assign dup        = |dup_vec;
    assign hs         = mem_req_valid_o && mem_req_ready_i;
    assign load       = (!mem_req_valid_o || hs) && issue_found;
    assign resp_hit   = |resp_vec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NENTRY; i++) begin
                state_q[i] <= FREE;
                line_q[i]  <= '0;
            end
            req_idx_q       <= '0;
            mem_req_valid_o <= 1'b0;
            mem_req_addr_o  <= '0;
            fill_valid_o    <= 1'b0;
            fill_prefetch_o <= 1'b0;
            fill_address_o  <= '0;
            drop_count_o    <= '0;
        end else begin
            for (int i = 0; i < NENTRY; i++) begin
                if (resp_vec[i]) state_q[i] <= FREE;
            end
            if (hs) state_q[req_idx_q] <= ISSUED;
            if (accept && !dup) begin
                state_q[alloc_idx] <= PENDING;
                line_q[alloc_idx]  <= pf_line;
            end
            if (accept && dup && drop_count_o != 16'hFFFF) begin
                drop_count_o <= drop_count_o + 16'd1;
            end
            if (load) begin
                mem_req_valid_o <= 1'b1;
                mem_req_addr_o  <= {line_q[issue_idx], {LOGLINE{1'b0}}};
                req_idx_q       <= issue_idx;
            end else if (hs) begin
                mem_req_valid_o <= 1'b0;
                mem_req_addr_o  <= '0;
            end
            fill_valid_o    <= resp_hit;
            fill_prefetch_o <= resp_hit;
            fill_address_o  <= resp_hit ? {resp_line, {LOGLINE{1'b0}}} : '0;
        end
    end

endmodule

// File: tb/tb_prefetch_receiver.sv
// Scoreboard bench for prefetch_receiver: directed scenarios push
// expected memory requests and fills; a monitor pops and compares.
module tb_prefetch_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] pf_address_i = '0;
    logic        pf_valid_i = 1'b0;
    logic        pf_ready_o;
    logic [63:0] mem_req_addr_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b1;
    logic        mem_resp_valid_i = 1'b0;
    logic [63:0] mem_resp_addr_i = '0;
    logic [63:0] fill_address_o;
    logic        fill_prefetch_o;
    logic        fill_valid_o;
    logic [15:0] drop_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] req_q  [$];
    logic [63:0] fill_q [$];

    localparam logic [63:0] LMASK = ~64'h3f;

    prefetch_receiver #(.WIDTH(64), .LOGLINE(6), .NENTRY(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .pf_address_i     (pf_address_i),
        .pf_valid_i       (pf_valid_i),
        .pf_ready_o       (pf_ready_o),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_addr_i  (mem_resp_addr_i),
        .fill_address_o   (fill_address_o),
        .fill_prefetch_o  (fill_prefetch_o),
        .fill_valid_o     (fill_valid_o),
        .drop_count_o     (drop_count_o)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act,
                                logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void unexpected(string name, logic [63:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got unexpected %h expected none", name, act);
    endfunction

    // Monitor: compares every memory handshake and every fill pulse.
    always @(negedge clk) begin
        if (mem_req_valid_o && mem_req_ready_i) begin
            if (req_q.size() == 0) unexpected("mem_req", mem_req_addr_o);
            else chk("mem_req_addr", mem_req_addr_o, req_q.pop_front());
        end
        if (!mem_req_valid_o) chk("mem_req_addr_idle", mem_req_addr_o, 64'h0);
        if (fill_valid_o) begin
            chk("fill_prefetch", {63'h0, fill_prefetch_o}, 64'h1);
            if (fill_q.size() == 0) unexpected("fill", fill_address_o);
            else chk("fill_addr", fill_address_o, fill_q.pop_front());
        end else begin
            chk("fill_addr_idle", fill_address_o, 64'h0);
        end
    end

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // kind: 0 duplicate, 1 new and later issued, 2 new never issued
    task automatic send_pf(input logic [63:0] a, input int kind);
        chk("pf_ready_before_send", {63'h0, pf_ready_o}, 64'h1);
        pf_address_i = a;
        pf_valid_i   = 1'b1;
        step();
        pf_valid_i   = 1'b0;
        pf_address_i = '0;
        if (kind == 1) req_q.push_back(a & LMASK);
    endtask

    task automatic send_resp(input logic [63:0] a, input bit fill);
        mem_resp_addr_i  = a;
        mem_resp_valid_i = 1'b1;
        step();
        mem_resp_valid_i = 1'b0;
        mem_resp_addr_i  = '0;
        if (fill) fill_q.push_back(a & LMASK);
        chk(fill ? "fill_pulse" : "no_fill",
            {63'h0, fill_valid_o}, {63'h0, fill});
    endtask

    task automatic chk_reset_outputs();
        chk("rst_mem_valid", {63'h0, mem_req_valid_o}, 64'h0);
        chk("rst_mem_addr", mem_req_addr_o, 64'h0);
        chk("rst_fill_valid", {63'h0, fill_valid_o}, 64'h0);
        chk("rst_fill_pf", {63'h0, fill_prefetch_o}, 64'h0);
        chk("rst_fill_addr", fill_address_o, 64'h0);
        chk("rst_drop", {48'h0, drop_count_o}, 64'h0);
        chk("rst_pf_ready", {63'h0, pf_ready_o}, 64'h1);
    endtask

    initial begin
        #2;
        chk_reset_outputs();
        step(2);
        rst = 1'b1;
        step();

        // Single request: latency and one-cycle fill
        send_pf(64'h1040, 1);
        chk("lat_t_valid", {63'h0, mem_req_valid_o}, 64'h0);
        step();
        chk("lat_t1_valid", {63'h0, mem_req_valid_o}, 64'h1);
        chk("lat_t1_addr", mem_req_addr_o, 64'h1040);
        step();
        send_resp(64'h1044, 1);
        chk("fill_addr_0x1040", fill_address_o, 64'h1040);
        step();
        chk("fill_one_cycle", {63'h0, fill_valid_o}, 64'h0);

        // Same-line duplicate
        send_pf(64'h2000, 1);
        send_pf(64'h2010, 0);
        chk("drop_after_dup", {48'h0, drop_count_o}, 64'h1);
        step(3);
        send_resp(64'h2000, 1);
        step();

        // Stall: address held, pending entry ignores responses
        mem_req_ready_i = 1'b0;
        send_pf(64'h3000, 1);
        step();
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", {63'h0, mem_req_valid_o}, 64'h1);
            chk("stall_addr", mem_req_addr_o, 64'h3000);
            if (k == 2) send_resp(64'h3000, 0);
            else step();
        end
        mem_req_ready_i = 1'b1;
        step();
        chk("stall_released", {63'h0, mem_req_valid_o}, 64'h0);
        send_resp(64'h3000, 1);
        step();

        // Stray response
        send_resp(64'h9000, 0);
        chk("stray_pf_ready", {63'h0, pf_ready_o}, 64'h1);
        step();

        // Fill the table
        mem_req_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) send_pf(64'h10000 + 64'(i) * 64'h40, 1);
        chk("full_pf_ready", {63'h0, pf_ready_o}, 64'h0);
        pf_address_i = 64'h20000;
        pf_valid_i   = 1'b1;
        step();
        pf_valid_i   = 1'b0;
        chk("full_no_drop", {48'h0, drop_count_o}, 64'h1);
        mem_req_ready_i = 1'b1;
        step();
        mem_req_ready_i = 1'b0;
        chk("full_still_full", {63'h0, pf_ready_o}, 64'h0);
        send_resp(64'h10000, 1);
        chk("freed_pf_ready", {63'h0, pf_ready_o}, 64'h1);
        mem_req_ready_i = 1'b1;
        step(9);
        for (int i = 1; i < 8; i++) send_resp(64'h10000 + 64'(i) * 64'h40, 1);
        step();

        // Accept and free of the same line in one cycle
        send_pf(64'h5000, 1);
        step(3);
        pf_address_i     = 64'h5000;
        pf_valid_i       = 1'b1;
        mem_resp_addr_i  = 64'h5008;
        mem_resp_valid_i = 1'b1;
        step();
        pf_valid_i       = 1'b0;
        mem_resp_valid_i = 1'b0;
        fill_q.push_back(64'h5000);
        chk("same_cycle_fill", {63'h0, fill_valid_o}, 64'h1);
        chk("same_cycle_drop", {48'h0, drop_count_o}, 64'h2);
        step(3);
        chk("same_cycle_no_req", {63'h0, mem_req_valid_o}, 64'h0);

        // Reset with three issued and one presented entry
        send_pf(64'h6000, 1);
        send_pf(64'h6040, 1);
        send_pf(64'h6080, 1);
        step(5);
        mem_req_ready_i = 1'b0;
        send_pf(64'h60c0, 2);
        step();
        chk("pre_rst_valid", {63'h0, mem_req_valid_o}, 64'h1);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs();
        step();
        rst = 1'b1;
        mem_req_ready_i = 1'b1;
        step();
        send_resp(64'h6000, 0);
        send_resp(64'h6040, 0);
        send_resp(64'h6080, 0);
        send_resp(64'h60c0, 0);
        step(3);
        chk("post_rst_drop", {48'h0, drop_count_o}, 64'h0);

        chk("req_q_drained", 64'(req_q.size()), 64'h0);
        chk("fill_q_drained", 64'(fill_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
